// File: rtl/apb_master_seq.sv
// apb_master_seq: single-outstanding APB master.
// Takes one command on a valid/ready handshake, runs one APB SETUP/ACCESS
// transfer and returns read data and status on a response handshake.
// Optional build macro: APB_MASTER_TIMEOUT_EN adds a wait-state watchdog
// that aborts an ACCESS phase after TIMEOUT consecutive PREADY-low edges.
module apb_master_seq #(
   parameter int ADDRESSWIDTH = 4,
   parameter int DATAWIDTH    = 8,
   parameter int TIMEOUT      = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDRESSWIDTH-1:0] cmd_addr,
   input  logic [DATAWIDTH-1:0]    cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATAWIDTH-1:0]    rsp_rdata,
   output logic                    rsp_err,
   output logic [ADDRESSWIDTH-1:0] PADDR,
   output logic [DATAWIDTH-1:0]    PWDATA,
   output logic                    PWRITE,
   output logic                    PSELx,
   output logic                    PENABLE,
   input  logic [DATAWIDTH-1:0]    PRDATA,
   input  logic                    PREADY
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
   logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATAWIDTH-1:0]    rdata_q, rdata_d;

   // A watchdog limit of zero would abort before the slave could ever answer.
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("apb_master_seq: TIMEOUT must be >= 1");
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic          err_q, err_d;
   logic          tmo;

   // The edge being sampled is the TIMEOUT-th consecutive low edge.
   assign tmo = (wcnt_q == CW'(TIMEOUT - 1));
`endif

   // Next-state and datapath: capture the command, walk SETUP/ACCESS, hold the response.
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
      rdata_d  = rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
      wcnt_d   = wcnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            // Reset holds the FSM in IDLE, so cmd_ready here is just IDLE.
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               pwrite_d = cmd_write;
               state_d  = S_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
               wcnt_d   = '0;
`endif
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (PREADY) begin
               // PREADY wins over a watchdog expiry on the same edge.
               rdata_d = pwrite_q ? '0 : PRDATA;
               state_d = S_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (tmo) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else if (wcnt_q != CW'(TIMEOUT)) begin
               wcnt_d  = wcnt_q + CW'(1);
            end
`endif
         end
         S_RESP: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; async reset discards any in-flight transfer.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= S_IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         rdata_q  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         wcnt_q   <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
         rdata_q  <= rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
         wcnt_q   <= wcnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign cmd_ready = (state_q == S_IDLE) && PRESETn;
   assign PSELx     = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign PENABLE   = (state_q == S_ACCESS);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PWRITE    = pwrite_q;
`ifdef APB_MASTER_TIMEOUT_EN
   assign rsp_err   = err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule
